bloque_switches: RTL and testbench
==================================

BLOQUE_SWITCHES -- requirements
Module: bloque_switches

Interface
REQ-001 Parameter ANCHO, default 32, data width of the processor bus.
REQ-002 Parameter DIRINTERNO, default 'h314, address of the status register; the event register is at DIRINTERNO+4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 100000, the number of stable clk cycles required before a debounced bit changes.
REQ-004 clk  input  1  the single clock; all state is on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 Dir  input  ANCHO  bus address.
REQ-007 Entrada  input  ANCHO  bus write data (write-1-to-clear mask for the event register).
REQ-008 RE  input  1  read strobe, one cycle.
REQ-009 WE  input  1  write strobe, one cycle.
REQ-010 sw  input  16  raw board switches, asynchronous to clk.
REQ-011 btn  input  5  raw board push-buttons, asynchronous to clk.
REQ-012 Salida  output  ANCHO  registered read data.
REQ-013 Listo  output  1  one-cycle pulse marking valid Salida.
REQ-014 irq  output  1  high while any event bit is set.

Function
REQ-015 Each sw and btn bit SHALL pass a 2-flop synchronizer before any other logic.
REQ-016 Each synchronized bit SHALL have its own debounce counter and stable bit; the counter clears whenever the synchronized value equals the stable value.
REQ-017 While the values differ, the counter SHALL increment each cycle; when it reaches DEBOUNCE_CYCLES-1, the stable bit takes the synchronized value and the counter clears.
REQ-018 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the stable bit unchanged.
REQ-019 The counter width SHALL be clog2(DEBOUNCE_CYCLES) bits, and the counter SHALL never wrap.
REQ-020 The status word SHALL be {zeros, btn_stable[4:0], sw_stable[15:0]}, with sw in bits 15:0 and btn in bits 20:16.
REQ-021 Event bits ev[4:0] SHALL be sticky and set on the cycle a debounced btn bit rises 0->1; falling edges SHALL be ignored.
REQ-022 If RE is high and Dir==DIRINTERNO, then on the next edge Salida SHALL be the status word and Listo SHALL be 1.
REQ-023 If RE is high and Dir==DIRINTERNO+4, then on the next edge Salida SHALL be {zeros, ev} and Listo SHALL be 1; on the same edge, all ev bits SHALL be cleared (read-to-clear).
REQ-024 If WE is high and Dir==DIRINTERNO+4, then ev SHALL be cleared where Entrada[4:0] is 1; writes to any other address SHALL be ignored.
REQ-025 If an ev bit is set by a rising edge on the same cycle it is cleared by a read or write, set SHALL win and the bit SHALL stay 1.
REQ-026 If RE is high with any other Dir, or RE is low, then Salida SHALL be 0 and Listo SHALL be 0 on the next edge.
REQ-027 If RE and WE are both high, the read SHALL be served first (it returns the pre-clear ev value); both clear masks then apply.
REQ-028 irq SHALL be a registered OR of ev and SHALL follow ev with zero extra latency (irq = |ev at the same edge).

Reset
REQ-029 rst SHALL asynchronously clear synchronizer flops, counters, stable bits, ev, Salida, Listo and irq to 0.
REQ-030 A rst asserted mid-debounce SHALL discard the count; after release, a held input SHALL need a full DEBOUNCE_CYCLES cycles again.
REQ-031 Because the stable bits reset to 0, a button held through reset release SHALL produce one event after debounce.

Structure
REQ-032 The register offsets (0, 4), the bit positions of the sw and btn fields, and the event count 5 SHALL live in the shared peripheral constants package.
REQ-033 The synchronizer plus debounce for one bit SHALL be one sub-module, antirrebote (parameter DEBOUNCE_CYCLES), instantiated 21 times.

Verification
REQ-034 With DEBOUNCE_CYCLES=4, set sw=16'hA5A5 and hold it 6 cycles, then read DIRINTERNO -> Salida=32'h0000A5A5 and Listo=1 exactly one cycle after RE.
REQ-035 Pulse btn[2] high for 2 cycles -> status bit 18 stays 0, ev stays 0, and irq stays 0.
REQ-036 Hold btn[0] and btn[4] for 10 cycles, then read DIRINTERNO+4 -> Salida=32'h11 and irq=1 before the read; a second read returns 0 and irq=0.
REQ-037 With ev=5'h03, write Entrada=32'h1 to DIRINTERNO+4 -> ev=5'h02; a debounced btn[0] rise on that same cycle leaves ev=5'h03.
REQ-038 Assert rst mid-count while btn[1] is held -> all outputs are 0 immediately; after release, btn[1] reaches stable after 2+4 cycles and ev[1]=1.
REQ-039 Read at DIRINTERNO+8 -> Salida=0, Listo=0, and no state changes.

Source files
------------

// File: rtl/bloque_switches_pkg.sv
// Shared peripheral constants for the switch/button block: register
// offsets, field positions inside the status word and the event count.
package bloque_switches_pkg;

    // Register offsets relative to the block base address
    localparam int OFF_STATUS = 0;
    localparam int OFF_EVENT  = 4;

    // Status word layout: sw in the low bits, btn right above
    localparam int SW_LSB  = 0;
    localparam int SW_W    = 16;
    localparam int BTN_LSB = 16;
    localparam int BTN_W   = 5;

    // One sticky event bit per push-button
    localparam int NUM_EV  = BTN_W;

    // Total number of debounced inputs
    localparam int NUM_IN  = SW_W + BTN_W;

    // What the bus read on this cycle selects
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_STATUS = 2'd1,
        RD_EVENT  = 2'd2
    } rd_sel_t;

endpackage

// File: rtl/bloque_switches_antirrebote.sv
// Synchronizer plus debouncer for a single raw board input.
// The stable output only changes after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clk cycles.
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable,
    output logic rise
);

    // A count of DEBOUNCE_CYCLES-1 is the largest value ever held, so
    // clog2 bits are enough and the counter never wraps.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          done;

    assign done = (cnt == CNT_MAX);

    // Two-flop synchronizer for the asynchronous board input
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // with = the second stage would copy din in the same cycle and the
    // synchronizer would collapse to one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
        end
    end

    // Count consecutive disagreeing cycles; commit the new value at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (done) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // High in the cycle whose edge will move stable from 0 to 1, so the
    // parent can register an event on the same edge stable rises.
    assign rise = ~stable & sync & done;

endmodule

// File: rtl/bloque_switches.sv
// Memory-mapped switch and push-button peripheral: debounces 16 switches
// and 5 buttons, exposes them in a status register, and latches sticky
// button-press events that raise irq until cleared by read or write.
module bloque_switches
    import bloque_switches_pkg::*;
#(
    parameter int          ANCHO           = 32,
    parameter int unsigned DIRINTERNO      = 'h314,
    parameter int          DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ANCHO-1:0] Dir,
    input  logic [ANCHO-1:0] Entrada,
    input  logic             RE,
    input  logic             WE,
    input  logic [15:0]      sw,
    input  logic [4:0]       btn,
    output logic [ANCHO-1:0] Salida,
    output logic             Listo,
    output logic             irq
);

    localparam logic [ANCHO-1:0] DIR_STATUS = ANCHO'(DIRINTERNO + OFF_STATUS);
    localparam logic [ANCHO-1:0] DIR_EVENT  = ANCHO'(DIRINTERNO + OFF_EVENT);

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] stable;
    logic [NUM_IN-1:0] rise_all;
    logic [SW_W-1:0]   sw_stable;
    logic [BTN_W-1:0]  btn_stable;
    logic [BTN_W-1:0]  btn_rise;

    logic [NUM_EV-1:0] ev;
    logic [NUM_EV-1:0] ev_clr;
    logic [NUM_EV-1:0] ev_next;
    rd_sel_t           rd_sel;
    logic [ANCHO-1:0]  status;
    logic [ANCHO-1:0]  rdata;

    // Switch events are not used and the write mask only has NUM_EV bits
    logic unused_bits;
    assign unused_bits = ^{Entrada[ANCHO-1:NUM_EV], rise_all[SW_W-1:0]};

    assign raw        = {btn, sw};
    assign sw_stable  = stable[SW_W-1:0];
    assign btn_stable = stable[NUM_IN-1:SW_W];
    assign btn_rise   = rise_all[NUM_IN-1:SW_W];

    // One synchronizer+debouncer per raw input bit
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_deb
        antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .din   (raw[gi]),
            .stable(stable[gi]),
            .rise  (rise_all[gi])
        );
    end

    // Bus decode, read mux and next event state
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        rd_sel = RD_NONE;
        ev_clr = '0;
        status = '0;
        rdata  = '0;

        status[SW_LSB  +: SW_W]  = sw_stable;
        status[BTN_LSB +: BTN_W] = btn_stable;

        if (RE && Dir == DIR_STATUS) begin
            rd_sel = RD_STATUS;
        end else if (RE && Dir == DIR_EVENT) begin
            rd_sel = RD_EVENT;
        end

        // The read returns the pre-clear ev; both clear masks then combine
        case (rd_sel)
            RD_STATUS: rdata = status;
            RD_EVENT: begin
                rdata[NUM_EV-1:0] = ev;
                ev_clr            = '1;
            end
            default:   rdata = '0;
        endcase

        if (WE && Dir == DIR_EVENT) begin
            ev_clr = ev_clr | Entrada[NUM_EV-1:0];
        end

        // A rise on the clearing edge wins over the clear
        ev_next = (ev & ~ev_clr) | btn_rise;
    end

    // Registered read data, ready pulse, sticky events and interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Salida <= '0;
            Listo  <= 1'b0;
            ev     <= '0;
            irq    <= 1'b0;
        end else begin
            Salida <= rdata;
            Listo  <= (rd_sel != RD_NONE);
            ev     <= ev_next;
            irq    <= |ev_next;
        end
    end

endmodule

// File: tb/tb_bloque_switches.sv
// Bench for bloque_switches with a short debounce window: fixed vector
// table, hand sequences for multi-cycle corner cases, then random stimulus
// against a cycle-level reference model of the peripheral.
module tb_bloque_switches;

    localparam int          D    = 4;
    localparam int unsigned BASE = 'h314;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Dir;
    logic [31:0] Entrada;
    logic        RE;
    logic        WE;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic [31:0] Salida;
    logic        Listo;
    logic        irq;

    bloque_switches #(
        .ANCHO          (32),
        .DIRINTERNO     (BASE),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .Dir    (Dir),
        .Entrada(Entrada),
        .RE     (RE),
        .WE     (WE),
        .sw     (sw),
        .btn    (btn),
        .Salida (Salida),
        .Listo  (Listo),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per input: the last two raw samples (the synchronizer delay), the
    // current debounced value and how many edges in a row the delayed
    // sample has disagreed with it.
    bit          m_s1[21];
    bit          m_s2[21];
    bit          m_stab[21];
    int          m_run[21];
    logic [4:0]  m_ev;
    logic [31:0] m_salida;
    logic        m_listo;
    logic        m_irq;

    task automatic model_reset();
        for (int b = 0; b < 21; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_run[b] = 0;
        end
        m_ev = '0; m_salida = '0; m_listo = 1'b0; m_irq = 1'b0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] st;
        st = '0;
        for (int b = 0; b < 21; b++) st[b] = m_stab[b];
        return st;
    endfunction

    task automatic model_step();
        logic [20:0] raw;
        logic [31:0] st;
        logic [4:0]  rises;
        logic [4:0]  clr;
        raw   = {btn, sw};
        st    = m_status();
        rises = '0;
        clr   = '0;
        for (int b = 0; b < 21; b++) begin
            if (m_s2[b] != m_stab[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    m_stab[b] = m_s2[b];
                    m_run[b]  = 0;
                    if (b >= 16 && m_stab[b]) rises[b - 16] = 1'b1;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        if (RE && Dir == BASE) begin
            m_salida = st; m_listo = 1'b1;
        end else if (RE && Dir == BASE + 4) begin
            m_salida = {27'd0, m_ev}; m_listo = 1'b1; clr = 5'h1f;
        end else begin
            m_salida = '0; m_listo = 1'b0;
        end
        if (WE && Dir == BASE + 4) clr = clr | Entrada[4:0];
        m_ev  = (m_ev & ~clr) | rises;
        m_irq = (m_ev != 0);
        for (int b = 0; b < 21; b++) begin
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare just after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check("model_salida", Salida, m_salida);
        check("model_listo", {31'd0, Listo}, {31'd0, m_listo});
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic idle(input int n);
        RE = 1'b0; WE = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_op(input logic re, input logic we, input logic [31:0] dir, input logic [31:0] ent);
        RE = re; WE = we; Dir = dir; Entrada = ent;
        tick();
        RE = 1'b0; WE = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] sw;
        logic [4:0]  btn;
        int          hold;
        logic        re;
        logic        we;
        logic [31:0] dir;
        logic [31:0] entrada;
        logic [31:0] exp_salida;
        logic        exp_listo;
        logic        exp_pre_irq;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[9];

    initial begin
        //               sw        btn    hold re    we    dir          entrada   salida         listo pre   irq
        vecs[0] = '{16'hA5A5, 5'h00, 6,  1'b1, 1'b0, BASE,       32'h0,  32'h0000A5A5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{16'hA5A5, 5'h11, 10, 1'b1, 1'b0, BASE + 4,   32'h0,  32'h00000011, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'hA5A5, 5'h11, 1,  1'b1, 1'b0, BASE + 4,   32'h0,  32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'hA5A5, 5'h00, 6,  1'b1, 1'b0, BASE,       32'h0,  32'h0000A5A5, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'hA5A5, 5'h00, 0,  1'b1, 1'b0, BASE + 8,   32'h0,  32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 5'h04, 6,  1'b1, 1'b0, BASE,       32'h0,  32'h0004FFFF, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{16'hFFFF, 5'h04, 0,  1'b0, 1'b1, BASE + 4,   32'h4,  32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 5'h00, 6,  1'b0, 1'b0, 32'h0,      32'h0,  32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'hFFFF, 5'h01, 6,  1'b1, 1'b1, BASE + 4,   32'h1f, 32'h00000001, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; RE = 1'b0; WE = 1'b0; Dir = '0; Entrada = '0; sw = '0; btn = '0;
        model_reset();
        tick(); tick();
        check("reset_salida", Salida, 32'h0);
        check("reset_listo", {31'd0, Listo}, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            sw = vecs[i].sw; btn = vecs[i].btn;
            idle(vecs[i].hold);
            check($sformatf("vec%0d_pre_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_pre_irq});
            do_op(vecs[i].re, vecs[i].we, vecs[i].dir, vecs[i].entrada);
            check($sformatf("vec%0d_salida", i), Salida, vecs[i].exp_salida);
            check($sformatf("vec%0d_listo", i), {31'd0, Listo}, {31'd0, vecs[i].exp_listo});
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // Two-cycle glitch on btn[2] is filtered out
        btn = 5'h00; idle(6);
        btn = 5'h04; tick(); tick();
        btn = 5'h00; idle(8);
        check("glitch_irq", {31'd0, irq}, 32'h0);
        do_op(1'b1, 1'b0, BASE, 32'h0);
        check("glitch_status", Salida, 32'h0000FFFF);
        do_op(1'b1, 1'b0, BASE + 4, 32'h0);
        check("glitch_ev", Salida, 32'h0);

        // Write-1-to-clear of a single event bit
        btn = 5'h03; idle(6);
        check("w1c_irq_set", {31'd0, irq}, 32'h1);
        btn = 5'h02; idle(6);
        do_op(1'b0, 1'b1, BASE + 4, 32'h1);
        do_op(1'b1, 1'b0, BASE + 4, 32'h0);
        check("w1c_ev", Salida, 32'h2);

        // Rise of btn[0] on the clearing write edge keeps ev[0] set
        btn = 5'h00; idle(6);
        btn = 5'h03; idle(6);
        btn = 5'h02; idle(6);
        btn = 5'h03; idle(5);
        do_op(1'b0, 1'b1, BASE + 4, 32'h1);
        check("setwins_irq", {31'd0, irq}, 32'h1);
        do_op(1'b1, 1'b0, BASE + 4, 32'h0);
        check("setwins_ev", Salida, 32'h3);

        // Reset in the middle of a btn[1] debounce
        btn = 5'h10; idle(6);
        btn = 5'h12; idle(3);
        do_op(1'b1, 1'b0, BASE, 32'h0);
        check("prerst_status", Salida, 32'h0010FFFF);
        check("prerst_irq", {31'd0, irq}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_async_salida", Salida, 32'h0);
        check("rst_async_listo", {31'd0, Listo}, 32'h0);
        check("rst_async_irq", {31'd0, irq}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        idle(5);
        check("postrst_irq_early", {31'd0, irq}, 32'h0);
        tick();
        check("postrst_irq", {31'd0, irq}, 32'h1);
        do_op(1'b1, 1'b0, BASE, 32'h0);
        check("postrst_status", Salida, 32'h0012FFFF);
        do_op(1'b1, 1'b0, BASE + 4, 32'h0);
        check("postrst_ev", Salida, 32'h12);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5, 0) == 0) begin
                int k;
                k = $urandom_range(15, 0);
                sw[k] = ~sw[k];
            end
            if ($urandom_range(9, 0) == 0) begin
                int k;
                k = $urandom_range(4, 0);
                btn[k] = ~btn[k];
            end
            RE = ($urandom_range(2, 0) == 0);
            WE = ($urandom_range(3, 0) == 0);
            case ($urandom_range(3, 0))
                0:       Dir = BASE;
                1:       Dir = BASE + 4;
                2:       Dir = BASE + 8;
                default: Dir = $urandom;
            endcase
            Entrada = $urandom;
            tick();
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
